mac8_sequencer: RTL

//  Sequences the 8x8 Vedic multiplier as a multiply-accumulate engine.
//  A start pulse sets a job of `len` operand pairs. Pairs are accepted over a

---
 rtl/mac8_pkg.sv | 29 ++
 rtl/mac8_if.sv | 27 ++
 rtl/vedic_8bit_multiplier.sv | 18 +
 rtl/mac8_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/mac8_pkg.sv
// Shared types, default widths and Vedic partial-product helpers for the MAC8 sequencer.
package mac8_pkg;

  localparam int unsigned ACC_W_DEF = 24;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

  // Urdhva-tiryagbhyam 2x2 cell: vertical and crosswise bit products.
  function automatic logic [3:0] vedic_mul2(input logic [1:0] a, input logic [1:0] b);
    logic p0, x0, x1, c1, v1;
    p0 = a[0] & b[0];
    x0 = a[1] & b[0];
    x1 = a[0] & b[1];
    c1 = x0 & x1;
    v1 = a[1] & b[1];
    return {v1 & c1, v1 ^ c1, x0 ^ x1, p0};
  endfunction

  function automatic logic [7:0] vedic_mul4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] q0, q1, q2, q3;
    q0 = vedic_mul2(a[1:0], b[1:0]);
    q1 = vedic_mul2(a[3:2], b[1:0]);
    q2 = vedic_mul2(a[1:0], b[3:2]);
    q3 = vedic_mul2(a[3:2], b[3:2]);
    return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
  endfunction

endpackage

// File: rtl/mac8_if.sv
// Job control, operand stream and result stream of the MAC8 sequencer.
interface mac8_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_ready;
  logic             out_valid;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic             out_ready;
  logic             busy;

  modport master (
    output start, len, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, busy
  );
endinterface

// File: rtl/vedic_8bit_multiplier.sv
// Combinational 8x8 unsigned Vedic multiplier built from 4x4 and 2x2 cells.
module vedic_8bit_multiplier
  import mac8_pkg::*;
(
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] r0, r1, r2, r3;

  always_comb begin
    r0 = vedic_mul4(a[3:0], b[3:0]);
    r1 = vedic_mul4(a[7:4], b[3:0]);
    r2 = vedic_mul4(a[3:0], b[7:4]);
    r3 = vedic_mul4(a[7:4], b[7:4]);
    p  = {8'b0, r0} + {4'b0, r1, 4'b0} + {4'b0, r2, 4'b0} + {r3, 8'b0};
  end
endmodule

// File: rtl/mac8_sequencer.sv
// Multiply-accumulate job sequencer: operand reg -> product reg -> accumulator,
// with a start/len job interface and a valid/ready result port.
module mac8_sequencer
  import mac8_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  mac8_if.slave bus
);
  localparam int unsigned SumW = ACC_W + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       a_q, b_q;
  logic             s1_v_q, s2_v_q;
  logic [15:0]      p_q, prod;
  logic [SumW-1:0]  sum;
  logic             accept;
  logic             in_ready, out_valid;

  vedic_8bit_multiplier u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  assign accept = (state_q == StRun) && bus.in_valid;
  assign sum    = {1'b0, acc_q} + SumW'(p_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    if (s2_v_q) begin
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_q | sum[ACC_W];
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (bus.len != '0) begin
            cnt_d   = bus.len;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = StDrain;
        end
      end
      // The last pair is the only one still in flight once s1 empties.
      StDrain: begin
        if (s2_v_q && !s1_v_q) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s1_v_q  <= 1'b0;
      p_q     <= '0;
      s2_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      if (accept) begin
        a_q <= bus.in_a;
        b_q <= bus.in_b;
      end
      s1_v_q <= accept;
      p_q    <= prod;
      s2_v_q <= s1_v_q;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_acc   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
